// File: rtl/param_stack_pkg.sv
// Shared definitions for the parametrised LIFO stack: command encoding
// and the elaboration-time width helpers used by the stack and its storage.
package param_stack_pkg;

   // Command decode is formed as {pop, push}
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_REPL = 2'b11
   } op_e;

   // Ceiling log2; clog2(1) == 0
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // Larger of two integers, used to keep address widths at least one bit
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port and two combinational read
// ports (top of stack and peek). Contents are never reset; the stack
// controller tracks which entries are meaningful.
module stack_regfile
   import param_stack_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 10,
   localparam int AW    = max_int(1, clog2(DEPTH))
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    top_addr,
   output logic [WIDTH-1:0] top_data,
   input  logic [AW-1:0]    peek_addr,
   output logic [WIDTH-1:0] peek_data
);

   // The array spans every encodable address so that a read with an
   // out-of-range index (masked later by the controller) stays in bounds.
   localparam int SLOTS = 1 << AW;

   logic [WIDTH-1:0] mem [SLOTS];

   // Single write port; the controller already suppresses writes during reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign top_data  = mem[top_addr];
   assign peek_data = mem[peek_addr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with replace-top (push+pop in one cycle),
// occupancy count, almost_full, an arbitrary-depth peek port, sticky
// overflow/underflow flags and a synchronous clear. The stack pointer is
// the count itself: the top entry lives at count-1, new words go to count.
module param_stack
   import param_stack_pkg::*;
#(
   parameter  int WIDTH    = 4,
   parameter  int DEPTH    = 10,
   parameter  int AF_LEVEL = DEPTH - 1,
   localparam int CW       = clog2(DEPTH + 1),
   localparam int PW       = max_int(1, clog2(DEPTH))
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   input  logic [PW-1:0]    peek_idx,
   output logic [WIDTH-1:0] peek_data,
   output logic             peek_valid,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             almost_full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   // Index arithmetic is carried one bit wider than the count so that
   // count-1 and count-1-peek_idx never wrap into a plausible address
   // before the validity checks mask them.
   localparam int            EW      = CW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

   op_e              op;
   logic             we;
   logic [PW-1:0]    waddr;
   logic [PW-1:0]    top_addr;
   logic [PW-1:0]    peek_addr;
   logic [WIDTH-1:0] top_word;
   logic [WIDTH-1:0] peek_word;
   logic [EW-1:0]    count_ext;
   logic [EW-1:0]    idx_ext;

   assign op        = op_e'({pop, push});
   assign count_ext = EW'(count);
   assign idx_ext   = EW'(peek_idx);
   assign top_addr  = PW'(count_ext - EW'(1));
   assign peek_addr = PW'(count_ext - EW'(1) - idx_ext);

   // Status decode straight from the count register
   assign full        = (count == DEPTH_C);
   assign empty       = (count == '0);
   assign almost_full = (count >= AF_C);
   assign peek_valid  = (idx_ext < count_ext);

   // Output gating: nothing from storage leaks out unless it is a live entry
   assign data_out  = empty      ? '0 : top_word;
   assign peek_data = peek_valid ? peek_word : '0;

   // Storage write decode; reset and clear suppress every write so X or
   // stale commands during those cycles cannot disturb the array
   always_comb begin
      we    = 1'b0;
      waddr = PW'(count);
      if (!reset && !clear) begin
         unique case (op)
            OP_PUSH: we = !full;
            OP_REPL: begin
               we = 1'b1;
               if (!empty) begin
                  waddr = top_addr;
               end
            end
            default: we = 1'b0;
         endcase
      end
   end

   // Count and sticky error flags; clear outranks any command in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         unique case (op)
            OP_PUSH: begin
               if (full) begin
                  overflow <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            OP_POP: begin
               if (empty) begin
                  underflow <= 1'b1;
               end else begin
                  count <= count - 1'b1;
               end
            end
            OP_REPL: begin
               // Replace-top leaves the count alone; on an empty stack the
               // push half still lands and the missing pop is flagged
               if (empty) begin
                  count     <= CW'(1);
                  underflow <= 1'b1;
               end
            end
            default: count <= count;
         endcase
      end
   end

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_regfile (
      .clk       (clk),
      .we        (we),
      .waddr     (waddr),
      .wdata     (data_in),
      .top_addr  (top_addr),
      .top_data  (top_word),
      .peek_addr (peek_addr),
      .peek_data (peek_word)
   );

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: each command pushes the expected
// post-edge outputs from a queue-based stack model; a monitor pops and
// compares one entry after every rising edge.
module tb_param_stack;

   localparam int WIDTH    = 4;
   localparam int DEPTH    = 10;
   localparam int AF_LEVEL = DEPTH - 1;
   localparam int CW       = 4;
   localparam int PW       = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             clear;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic [PW-1:0]    peek_idx;
   logic [WIDTH-1:0] peek_data;
   logic             peek_valid;
   logic [CW-1:0]    count;
   logic             full;
   logic             almost_full;
   logic             empty;
   logic             overflow;
   logic             underflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int cnt;
      int dout;
      int pdata;
      int pvalid;
      int full;
      int af;
      int empty;
      int ov;
      int un;
   } exp_t;

   exp_t sbq[$];

   // Reference model: the stack as a queue, top at the back
   int stk[$];
   int m_ov;
   int m_un;

   param_stack #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .push        (push),
      .pop         (pop),
      .data_in     (data_in),
      .data_out    (data_out),
      .peek_idx    (peek_idx),
      .peek_data   (peek_data),
      .peek_valid  (peek_valid),
      .count       (count),
      .full        (full),
      .almost_full (almost_full),
      .empty       (empty),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_apply(input bit c, input bit pu, input bit po, input int din);
      if (c) begin
         stk.delete();
         m_ov = 0;
         m_un = 0;
      end else if (pu && po) begin
         if (stk.size() == 0) begin
            stk.push_back(din);
            m_un = 1;
         end else begin
            stk[stk.size()-1] = din;
         end
      end else if (pu) begin
         if (stk.size() == DEPTH) m_ov = 1;
         else stk.push_back(din);
      end else if (po) begin
         if (stk.size() == 0) m_un = 1;
         else void'(stk.pop_back());
      end
   endfunction

   function automatic exp_t snapshot(input int idx);
      exp_t e;
      int n;
      n        = stk.size();
      e.cnt    = n;
      e.dout   = (n > 0) ? stk[n-1] : 0;
      e.pvalid = (idx < n) ? 1 : 0;
      e.pdata  = (idx < n) ? stk[n-1-idx] : 0;
      e.full   = (n == DEPTH) ? 1 : 0;
      e.af     = (n >= AF_LEVEL) ? 1 : 0;
      e.empty  = (n == 0) ? 1 : 0;
      e.ov     = m_ov;
      e.un     = m_un;
      return e;
   endfunction

   // Issue one command at the falling edge and queue its expected result
   task automatic cmd(input bit c, input bit pu, input bit po, input int din, input int idx);
      @(negedge clk);
      clear    = c;
      push     = pu;
      pop      = po;
      data_in  = WIDTH'(din);
      peek_idx = PW'(idx);
      model_apply(c, pu, po, din & ((1 << WIDTH) - 1));
      sbq.push_back(snapshot(idx));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expected entry is due just after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_count",      32'(count),       32'(e.cnt));
            chk("sb_data_out",   32'(data_out),    32'(e.dout));
            chk("sb_peek_data",  32'(peek_data),   32'(e.pdata));
            chk("sb_peek_valid", 32'(peek_valid),  32'(e.pvalid));
            chk("sb_full",       32'(full),        32'(e.full));
            chk("sb_almost",     32'(almost_full), 32'(e.af));
            chk("sb_empty",      32'(empty),       32'(e.empty));
            chk("sb_overflow",   32'(overflow),    32'(e.ov));
            chk("sb_underflow",  32'(underflow),   32'(e.un));
         end
      end
   end

   initial begin
      int vals[4];
      int p;
      int dn;
      reset    = 1'b1;
      clear    = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      data_in  = '0;
      peek_idx = '0;
      m_ov     = 0;
      m_un     = 0;
      #1;
      chk("rst_count",      32'(count),       32'd0);
      chk("rst_empty",      32'(empty),       32'd1);
      chk("rst_full",       32'(full),        32'd0);
      chk("rst_almost",     32'(almost_full), 32'd0);
      chk("rst_overflow",   32'(overflow),    32'd0);
      chk("rst_underflow",  32'(underflow),   32'd0);
      chk("rst_data_out",   32'(data_out),    32'd0);
      chk("rst_peek_valid", 32'(peek_valid),  32'd0);
      chk("rst_peek_data",  32'(peek_data),   32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Four pushes, then peek at depth 2 and past the top
      vals = '{'hA, 'hF, 'h1, 'hA};
      foreach (vals[i]) cmd(0, 1, 0, vals[i], 0);
      cmd(0, 0, 0, 0, 2);
      step();
      chk("p4_count",      32'(count),      32'd4);
      chk("p4_data_out",   32'(data_out),   32'hA);
      chk("p4_peek2",      32'(peek_data),  32'hF);
      chk("p4_peek2_vld",  32'(peek_valid), 32'd1);
      #2 peek_idx = PW'(4);
      #1;
      chk("p4_peek4_vld",  32'(peek_valid), 32'd0);
      chk("p4_peek4_data", 32'(peek_data),  32'd0);

      // Two pops then a push
      cmd(0, 0, 1, 0, 1);
      step();
      chk("pop1_data_out", 32'(data_out), 32'h1);
      cmd(0, 0, 1, 0, 1);
      step();
      chk("pop2_data_out", 32'(data_out), 32'hF);
      cmd(0, 1, 0, 'hC, 1);
      step();
      chk("pushc_data_out", 32'(data_out),  32'hC);
      chk("pushc_count",    32'(count),     32'd3);
      chk("pushc_peek1",    32'(peek_data), 32'hF);

      // Fill to full, then overflow
      cmd(1, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         cmd(0, 1, 0, i, 0);
         step();
         if (i == DEPTH - 2) begin
            chk("fill9_almost", 32'(almost_full), 32'd1);
            chk("fill9_full",   32'(full),        32'd0);
         end
         if (i == DEPTH - 1) begin
            chk("fill10_full",     32'(full),     32'd1);
            chk("fill10_data_out", 32'(data_out), 32'h9);
         end
      end
      cmd(0, 1, 0, 'hE, 0);
      step();
      chk("ovf_count",    32'(count),    32'd10);
      chk("ovf_data_out", 32'(data_out), 32'h9);
      chk("ovf_flag",     32'(overflow), 32'd1);

      // Replace-top when full, then on an empty stack
      cmd(0, 1, 1, 'h7, 0);
      step();
      chk("replf_data_out", 32'(data_out), 32'h7);
      chk("replf_count",    32'(count),    32'd10);
      chk("replf_overflow", 32'(overflow), 32'd1);
      cmd(1, 0, 0, 0, 0);
      cmd(0, 1, 1, 'h7, 0);
      step();
      chk("reple_count",     32'(count),     32'd1);
      chk("reple_data_out",  32'(data_out),  32'h7);
      chk("reple_underflow", 32'(underflow), 32'd1);

      // Pop down to empty, pop again, then clear with a push pending
      cmd(0, 0, 1, 0, 0);
      cmd(0, 0, 1, 0, 0);
      step();
      chk("unf_count",    32'(count),     32'd0);
      chk("unf_data_out", 32'(data_out),  32'd0);
      chk("unf_flag",     32'(underflow), 32'd1);
      cmd(1, 1, 0, 'h5, 0);
      step();
      chk("clr_count",     32'(count),     32'd0);
      chk("clr_overflow",  32'(overflow),  32'd0);
      chk("clr_underflow", 32'(underflow), 32'd0);

      // Asynchronous reset at count=5 with a push held across it
      for (int i = 0; i < 5; i++) cmd(0, 1, 0, $urandom_range(0, 15), 0);
      @(negedge clk);
      push    = 1'b1;
      pop     = 1'b0;
      clear   = 1'b0;
      data_in = 4'h3;
      #1 reset = 1'b1;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      #2 reset = 1'b0;
      step();
      chk("arst_push_count",    32'(count),    32'd1);
      chk("arst_push_data_out", 32'(data_out), 32'h3);
      stk.delete();
      m_ov = 0;
      m_un = 0;
      stk.push_back(3);

      // Randomised traffic: push-heavy and pop-heavy phases, rare clears
      for (int i = 0; i < 600; i++) begin
         p  = $urandom_range(0, 99);
         dn = ((i / 75) % 2 == 0) ? 30 : 65;
         if ($urandom_range(0, 39) == 0)
            cmd(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
                $urandom_range(0, (1 << PW) - 1));
         else if (p < 15)
            cmd(0, 1, 1, $urandom_range(0, 15), $urandom_range(0, (1 << PW) - 1));
         else if (p < dn)
            cmd(0, 0, 1, $urandom_range(0, 15), $urandom_range(0, (1 << PW) - 1));
         else if (p < 92)
            cmd(0, 1, 0, $urandom_range(0, 15), $urandom_range(0, (1 << PW) - 1));
         else
            cmd(0, 0, 0, $urandom_range(0, 15), $urandom_range(0, (1 << PW) - 1));
      end

      @(negedge clk);
      push = 1'b0;
      pop  = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("sb_drain", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
